// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch stage.
// The optional IFETCH_ALIGN_CHECK_EN feature (misaligned-redirect fault)
// is selected inside ifetch.sv.
package ifetch_pkg;

  // Fetch sequencing states.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [31:0] INSN_BYTES         = 32'd4;
  localparam logic [31:0] IFETCH_RESET_PC    = 32'h0000_0000;
  localparam int          IFETCH_ADDR_WIDTH  = 14;
  localparam int          IFETCH_DATA_WIDTH  = 32;

  // A byte address is a legal instruction address only when word aligned.
  function automatic logic is_misaligned(input logic [31:0] byte_addr);
    return (byte_addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: ROM port, redirect port and decoder handshake of the fetch
// stage. master = fetch stage, slave = surrounding core (ROM/execute/decode).
interface ifetch_if
  import ifetch_pkg::*;
#(
  parameter int AW = IFETCH_ADDR_WIDTH,
  parameter int DW = IFETCH_DATA_WIDTH
);
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [31:0]   instr_pc;
  logic          fetch_fault;

  modport master (
    output rom_addr, instr_valid, instr, instr_pc, fetch_fault,
    input  rom_q, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  rom_addr, instr_valid, instr, instr_pc, fetch_fault,
    output rom_q, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifetch.sv
// ifetch: program counter and fetch sequencing in front of a synchronous
// instruction ROM with one cycle of read latency. pc_q always names the word
// currently on rom_q; the address issued this cycle becomes next cycle's pc_q.
// Optional macro IFETCH_ALIGN_CHECK_EN: misaligned redirects halt fetch and
// raise fetch_fault until an aligned redirect arrives.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = IFETCH_RESET_PC,
  parameter int          ADDRESS_WIDTH = IFETCH_ADDR_WIDTH,
  parameter int          DATA_WIDTH    = IFETCH_DATA_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  ifetch_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic        valid_s;
  logic        misaligned_s;
  logic [31:0] target_s;

  // A pending redirect kills the word on rom_q: it is on the wrong path.
  assign valid_s = (state_q == ST_RUN) && !bus.redirect_valid;

  // Redirect target qualification; without alignment checking the low two
  // bits are dropped so the word address is used.
  always_comb begin
    misaligned_s = 1'b0;
    target_s     = bus.redirect_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    misaligned_s = is_misaligned(bus.redirect_pc);
    target_s     = bus.redirect_pc;
`else
    misaligned_s = 1'b0;
    target_s     = bus.redirect_pc & ~32'h0000_0003;
`endif
  end

  // State, PC and fault registers; reset returns to BOOT at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Next state and issue PC (pc_d is the address sent to the ROM this cycle).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (bus.redirect_valid) begin
      pc_d = target_s;
      if (misaligned_s) begin
        state_d = ST_HALT;
        fault_d = 1'b1;
      end else begin
        state_d = ST_RUN;
        fault_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_RUN;
          pc_d    = pc_q;
        end
        ST_RUN: begin
          state_d = ST_RUN;
          if (bus.instr_ready) begin
            pc_d = pc_q + INSN_BYTES;
          end else begin
            pc_d = pc_q;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
          pc_d    = pc_q;
        end
        default: begin
          // Illegal encoding: restart fetch from the current PC.
          state_d = ST_BOOT;
          pc_d    = pc_q;
        end
      endcase
    end
  end

  // Outputs: ROM address from the issue PC, instruction passthrough.
  always_comb begin
    bus.rom_addr    = pc_d[ADDRESS_WIDTH+1:2];
    bus.instr_valid = valid_s;
    bus.instr       = bus.rom_q;
    bus.instr_pc    = pc_q;
    bus.fetch_fault = fault_q;
  end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed vector table, randomized run against a transaction
// level model, and a mid-stream reset sequence for ifetch.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;
`ifdef IFETCH_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ifetch_if #(.AW(AW), .DW(32)) bus ();

  ifetch #(.RESET_PC(32'h0000_0000), .ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Synchronous ROM, mem[i] = i.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) bus.rom_q <= mem[bus.rom_addr];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic        ef;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic rv, input logic [31:0] rpc, input logic rdy,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ei,
                              input logic ef);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev; v.epc = epc; v.ei = ei; v.ef = ef;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = rdy;
  endtask

  // Reference model state: word being presented, whether it is deliverable.
  logic [31:0] m_pc;
  bit          m_live, m_boot, m_fault;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = i;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b1);

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("reset_fault", {31'd0, bus.fetch_fault}, 32'd0);
    chk("reset_rom_addr", {18'd0, bus.rom_addr}, 32'd0);
    chk("reset_instr_pc", bus.instr_pc, 32'd0);

    // ---------------- directed table ----------------
    add(0, 32'h0, 1, 0, 32'h0, 32'h0, 0);               // boot bubble
    add(0, 32'h0, 1, 1, 32'h0, 32'h0, 0);
    add(0, 32'h0, 1, 1, 32'h4, 32'h1, 0);
    add(0, 32'h0, 0, 1, 32'h8, 32'h2, 0);               // stall x3
    add(0, 32'h0, 0, 1, 32'h8, 32'h2, 0);
    add(0, 32'h0, 0, 1, 32'h8, 32'h2, 0);
    add(0, 32'h0, 1, 1, 32'h8, 32'h2, 0);               // accepted
    add(0, 32'h0, 1, 1, 32'hC, 32'h3, 0);
    add(1, 32'h40, 1, 0, 32'h0, 32'h0, 0);              // kills pc 0x10
    add(0, 32'h0, 1, 1, 32'h40, 32'h10, 0);
    add(1, 32'h100, 0, 0, 32'h0, 32'h0, 0);             // redirect in stall
    add(1, 32'h200, 1, 0, 32'h0, 32'h0, 0);             // back-to-back
    add(1, 32'h300, 0, 0, 32'h0, 32'h0, 0);
    add(0, 32'h0, 1, 1, 32'h300, 32'hC0, 0);
    add(0, 32'h0, 1, 1, 32'h304, 32'hC1, 0);
    add(1, 32'h42, 1, 0, 32'h0, 32'h0, 0);              // misaligned target
    add(0, 32'h0, 1, !CHK, 32'h40, 32'h10, CHK);
    add(0, 32'h0, 1, !CHK, 32'h44, 32'h11, CHK);
    add(1, 32'h80, 1, 0, 32'h0, 32'h0, CHK);
    add(0, 32'h0, 1, 1, 32'h80, 32'h20, 0);
    add(1, 32'hFFFF_FFFC, 1, 0, 32'h0, 32'h0, 0);       // wrap
    add(0, 32'h0, 1, 1, 32'hFFFF_FFFC, 32'h3FFF, 0);
    add(0, 32'h0, 1, 1, 32'h0, 32'h0, 0);
    add(1, 32'h0001_0010, 1, 0, 32'h0, 32'h0, 0);       // alias above ROM size
    add(0, 32'h0, 1, 1, 32'h0001_0010, 32'h4, 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.instr_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_fault", i), {31'd0, bus.fetch_fault}, {31'd0, vecs[i].ef});
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_pc", i), bus.instr_pc, vecs[i].epc);
        chk($sformatf("vec%0d_instr", i), bus.instr, vecs[i].ei);
      end
      @(negedge clk);
    end

    // ---------------- randomized run vs model ----------------
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    #1;
    @(negedge clk);
    rst_n   = 1'b1;
    m_pc    = 32'h0;
    m_live  = 0;
    m_boot  = 1;
    m_fault = 0;
    for (int n = 0; n < 400; n++) begin
      logic        rv, rdy, ev;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = $urandom_range(0, 255) << 2;
      if ($urandom_range(0, 4) == 0) rpc = rpc | $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) rpc = rpc | ($urandom() & 32'hFFFF_0000);
      drive(rv, rpc, rdy);
      #1;
      ev = m_live && !rv;
      chk("rand_valid", {31'd0, bus.instr_valid}, {31'd0, ev});
      chk("rand_fault", {31'd0, bus.fetch_fault}, {31'd0, m_fault});
      if (ev) begin
        chk("rand_pc", bus.instr_pc, m_pc);
        chk("rand_instr", bus.instr, (m_pc >> 2) % DEPTH);
      end
      // Model: what the stage presents next cycle.
      if (rv) begin
        m_boot = 0;
        if (CHK && (rpc % 4 != 0)) begin
          m_pc = rpc; m_live = 0; m_fault = 1;
        end else begin
          m_pc = rpc - (rpc % 4); m_live = 1; m_fault = 0;
        end
      end else if (m_boot) begin
        m_boot = 0; m_live = 1;
      end else if (ev && rdy) begin
        m_pc = m_pc + 32'd4;
      end
      @(negedge clk);
    end

    // ---------------- reset asserted mid-stream ----------------
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);                       // boot cycle elapses
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("stream_pc%0d", k), bus.instr_pc, k * 4);
      if (k < 9) @(negedge clk);
    end
    rst_n = 1'b0;                         // pc 0x24 on the bus
    #1;
    chk("midrst_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("midrst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    chk("midrst_rom_addr", {18'd0, bus.rom_addr}, 32'd0);
    chk("midrst_pc", bus.instr_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_boot_valid", {31'd0, bus.instr_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("restart_valid", {31'd0, bus.instr_valid}, 32'd1);
    chk("restart_pc", bus.instr_pc, 32'd0);
    chk("restart_instr", bus.instr, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
